// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a registered req/ready fetch to imem,
// holds one instruction for ID, and steers on redirects/exceptions.
// Optional feature macro: IF_MISALIGN_TRAP_EN (trap misaligned redirect targets to XADR_VEC).
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter logic [31:0] ILLOP_VEC = 32'h8000_0004,
  parameter logic [31:0] XADR_VEC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        illop,
  input  logic        xadr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IFInstruction,
  output logic [31:0] IFPC,
  output logic        if_valid,
  output logic        if_misalign
);

  typedef enum logic {FETCH, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic        req_q, req_d;
  logic [31:0] slot_instr_q, slot_instr_d;
  logic [31:0] slot_pc_q, slot_pc_d;
  logic        slot_valid_q, slot_valid_d;
  logic        misalign_q, misalign_d;

  logic        done;
  logic        take;
  logic [31:0] target;

  assign done = req_q && imem_ready;
  assign take = illop || xadr || redirect;

  // Target selection follows the priority illop > xadr > redirect.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    target     = {redirect_pc[31:2], 2'b00};
    misalign_d = 1'b0;
    if (illop) begin
      target = ILLOP_VEC;
    end else if (xadr) begin
      target = XADR_VEC;
    end else if (redirect) begin
`ifdef IF_MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) begin
        target     = XADR_VEC;
        misalign_d = 1'b1;
      end
`endif
    end
  end

`ifndef IF_MISALIGN_TRAP_EN
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_pc_d = pending_pc_q;
    slot_instr_d = slot_instr_q;
    slot_pc_d    = slot_pc_q;
    slot_valid_d = slot_valid_q;

    if (slot_valid_q && !stall) begin
      slot_valid_d = 1'b0;
      slot_instr_d = '0;
      slot_pc_d    = '0;
    end

    if (take) begin
      slot_valid_d = 1'b0;
      slot_instr_d = '0;
      slot_pc_d    = '0;
      if (!req_q || done) begin
        pc_d    = target;
        state_d = FETCH;
      end else begin
        pending_pc_d = target;
        state_d      = DRAIN;
      end
    end else if (done) begin
      if (state_q == FETCH) begin
        slot_valid_d = 1'b1;
        slot_instr_d = imem_rdata;
        slot_pc_d    = pc_q;
        pc_d         = pc_q + 32'd4;
      end else begin
        pc_d    = pending_pc_q;
        state_d = FETCH;
      end
    end

    // Only request when the slot is guaranteed empty for the returning data.
    req_d = (req_q && !done) ? 1'b1 : !slot_valid_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      pending_pc_q <= RESET_PC;
      req_q        <= 1'b0;
      slot_instr_q <= '0;
      slot_pc_q    <= '0;
      slot_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      req_q        <= req_d;
      slot_instr_q <= slot_instr_d;
      slot_pc_q    <= slot_pc_d;
      slot_valid_q <= slot_valid_d;
      misalign_q   <= misalign_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(done && slot_valid_q && stall));
    end
  end

  assign imem_req      = req_q;
  assign imem_addr     = pc_q;
  assign IFInstruction = slot_instr_q;
  assign IFPC          = slot_pc_q;
  assign if_valid      = slot_valid_q;
  assign if_misalign   = misalign_q;

endmodule
